// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's data-memory port.
// Serves word reads and byte-lane writes over big-endian lanes [0:3].
// Each request completes LATENCY edges after acceptance with a one-cycle
// mem_ready pulse. Out-of-range word indices raise mem_error and do not
// touch storage.
// Optional: define DMEM_ACCESS_COUNT_EN to add saturating rd_count/wr_count.
// DEPTH_WORDS must be >= 2; LATENCY must be in 1..15.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             mem_req,
  input  logic             mem_write_en,
  input  logic [31:0]      mem_addr,
  input  logic [3:0]       mem_byte_en,
  input  logic [0:3][7:0]  mem_data_in,
  output logic [0:3][7:0]  mem_data_out,
  output logic             mem_ready,
  output logic             mem_error,
  output logic             busy
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
`endif
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             we_q;
  logic [29:0]      widx_q;
  logic [3:0]       be_q;
  logic [0:3][7:0]  wdata_q;
  logic [0:3][7:0]  rdata_q;
  logic             ready_q;
  logic             error_q;
  logic             busy_q;

  // Storage is deliberately not reset.
  logic [0:3][7:0]  mem_q [DEPTH_WORDS];

  logic             commit;
  logic             in_range;
  logic [AW-1:0]    idx;

  // Byte-offset bits never select anything: the port is word addressed.
  logic             unused_addr;
  assign unused_addr = ^mem_addr[1:0];

  // Commit happens on the last BUSY edge; range check uses the full word index
  // so addresses past the end never alias onto low words.
  always_comb begin
    commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);
    in_range = (widx_q < DEPTH_W);
    idx      = widx_q[AW-1:0];
  end

  // Control FSM with registered ready/error/busy and read data.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mem_req) begin
            we_q    <= mem_write_en;
            widx_q  <= mem_addr[31:2];
            be_q    <= mem_byte_en;
            wdata_q <= mem_data_in;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (commit) begin
            if (!we_q) rdata_q <= in_range ? mem_q[idx] : '0;
            ready_q <= 1'b1;
            error_q <= !in_range;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Any mem_req seen here is dropped, not queued.
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Lane-masked write commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx][i] <= wdata_q[i];
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;
  assign mem_error    = error_q;
  assign busy         = busy_q;

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Saturating counters of successful (in-range) accesses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (commit && in_range) begin
      if (!we_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (we_q  && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (LATENCY = 2).
module tb_dmem_responder;

  logic        clk;
  logic        rst_b;
  logic        mem_req;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ready;
  logic        mem_error;
  logic        busy;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int errs   = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] exp_out;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_req      (mem_req),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_byte_en  (mem_byte_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready),
    .mem_error    (mem_error),
    .busy         (busy)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef DMEM_ACCESS_COUNT_EN
    chk({tag, " rd_count"}, rd_count, 32'(exp_rd));
    chk({tag, " wr_count"}, wr_count, 32'(exp_wr));
`endif
  endtask

  // One request; inputs are scrambled right after acceptance to prove capture.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data,
                        input logic exp_err);
    int n;
    logic got;
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = we; mem_addr = addr;
    mem_byte_en = be; mem_data_in = data;
    @(posedge clk); #1;
    mem_req = 1'b0; mem_write_en = ~we; mem_addr = addr ^ 32'h40;
    mem_byte_en = ~be; mem_data_in = ~data;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (mem_ready) got = 1'b1;
    end
    chk({tag, " latency"}, 32'(n), 32'd2);
    chk({tag, " error"}, {31'd0, mem_error}, {31'd0, exp_err});
    chk({tag, " data"}, mem_data_out, exp_out);
    if (!exp_err) begin
      if (we) exp_wr++; else exp_rd++;
    end
    chk_cnt(tag);
    @(posedge clk); #1;
    chk({tag, " ready drop"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, " error drop"}, {31'd0, mem_error}, 32'd0);
  endtask

  initial begin
    logic [11:0] busy_v, ready_v, busy_e, ready_e;
    logic saw_ready;

    rst_b = 1'b0; mem_req = 1'b0; mem_write_en = 1'b0;
    mem_addr = '0; mem_byte_en = '0; mem_data_in = '0;
    exp_out = 32'h0;
    #13;
    chk("reset ready", {31'd0, mem_ready}, 32'd0);
    chk("reset error", {31'd0, mem_error}, 32'd0);
    chk("reset busy",  {31'd0, busy}, 32'd0);
    chk("reset data",  mem_data_out, 32'd0);
    chk_cnt("reset");
    @(negedge clk); rst_b = 1'b1;

    // Full write then read back.
    do_req("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    exp_out = 32'hDEADBEEF;
    do_req("rd10", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);

    // Lane 2 only; other lanes carry junk that must be masked.
    do_req("wr10p", 1'b1, 32'h10, 4'b0100, 32'h11225544, 1'b0);
    exp_out = 32'hDEAD55EF;
    do_req("rd13", 1'b0, 32'h13, 4'h0, 32'h0, 1'b0);

    // Empty byte mask: completes, storage unchanged.
    do_req("wr10z", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0);
    do_req("rd10z", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);

    // Out of range: must not alias onto word 0.
    do_req("wr0", 1'b1, 32'h0, 4'hF, 32'h01020304, 1'b0);
    exp_out = 32'h0;
    do_req("rdoor", 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1);
    do_req("wroor", 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 1'b1);
    exp_out = 32'h01020304;
    do_req("rd0", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    do_req("wr20", 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
    exp_out = 32'hDEAD55EF;
    do_req("rd10b", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);

    // Held request: one acceptance every LATENCY+2 = 4 cycles.
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h10; mem_byte_en = 4'h0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      busy_v[k]  = busy;
      ready_v[k] = mem_ready;
      busy_e[k]  = (k % 4) != 3;
      ready_e[k] = (k % 4) == 2;
    end
    mem_req = 1'b0;
    exp_rd += 3;
    chk("hold busy",  {20'd0, busy_v},  {20'd0, busy_e});
    chk("hold ready", {20'd0, ready_v}, {20'd0, ready_e});
    chk("hold data",  mem_data_out, 32'hDEAD55EF);
    chk_cnt("hold");
    @(posedge clk); #1;
    chk("hold idle", {31'd0, busy}, 32'd0);

    // Reset during BUSY of a write to 0x20.
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h20;
    mem_byte_en = 4'hF; mem_data_in = 32'hAABBCCDD;
    @(posedge clk); #1;
    mem_req = 1'b0;
    chk("abort busy before", {31'd0, busy}, 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("abort busy",  {31'd0, busy}, 32'd0);
    chk("abort ready", {31'd0, mem_ready}, 32'd0);
    chk("abort data",  mem_data_out, 32'd0);
    exp_rd = 0; exp_wr = 0;
    chk_cnt("abort");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    saw_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ready || busy) saw_ready = 1'b1;
    end
    chk("abort no pulse", {31'd0, saw_ready}, 32'd0);
    chk_cnt("abort idle");
    exp_out = 32'h11223344;
    do_req("rd20", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Watchdog: stop a hung run with a failure line.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's data-memory interface. It serves word reads and byte-lane writes through big-endian byte lanes [0:3].
- Requests are captured and completed after a programmable latency.
- Completion is signalled with a one-cycle ready pulse, so the core can later be stalled on realistic memory timing.
- Sits between the core's mem_addr / mem_data_in / mem_write_en outputs and its mem_data_out input.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; byte address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, edges from request acceptance to access commit; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_req  input  1  request strobe; sampled only in IDLE.
- mem_write_en  input  1  1 = write, 0 = read; captured with mem_req.
- mem_addr  input  32  byte address; bits [1:0] ignored, word index = mem_addr[31:2].
- mem_byte_en  input  4  write lane enables; bit i enables lane i.
- mem_data_in  input  8x[0:3]  write data lanes; lane 0 = word bits 31:24 = byte at address +0.
- mem_data_out  output  8x[0:3]  read data lanes, same lane order.
- mem_ready  output  1  one-cycle completion pulse.
- mem_error  output  1  out-of-range flag, valid while mem_ready = 1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_b = 0):
  - state = IDLE, latency counter = 0.
  - mem_ready = 0, mem_error = 0, busy = 0, all mem_data_out lanes = 8'h00.
  - Storage contents are not reset.
- State machine:
  - IDLE: if mem_req = 1 at an edge, capture addr, write_en, byte_en and all four data lanes; load counter = LATENCY-1; go to BUSY. Otherwise stay.
  - BUSY: counter != 0: decrement. Counter == 0: commit the access at this edge, go to RESP.
  - RESP: mem_ready = 1 for exactly this cycle; next edge goes to IDLE unconditionally. mem_req in RESP is ignored, not queued.
- Timing:
  - Request accepted at edge E0 commits at edge E_LATENCY; mem_ready is high between E_LATENCY and E_LATENCY+1.
  - Minimum request spacing is LATENCY+2 cycles.
  - Inputs changing after E0 have no effect on the captured request.
- Commit, read: mem_data_out lanes load mem[word] and hold until the next committed read or reset. Writes do not change mem_data_out.
- Commit, write: each lane i with byte_en[i] = 1 is updated from the captured lane i; other lanes keep their old values. byte_en = 4'b0000 completes normally with no storage change.
- Range check: word index >= DEPTH_WORDS gives mem_error = 1 in RESP, no storage change, mem_data_out = 0 for reads. In-range accesses give mem_error = 0. mem_error is 0 outside RESP.
- Reset mid-operation: the captured request is discarded, a pending write is never committed, and no ready pulse is produced.
- Same-word read after write: the read returns the written data, because commits are sequential.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs rd_count [31:0] and wr_count [31:0].
  - Each increments by 1 at the commit edge of an in-range read or write respectively.
  - Error accesses are not counted.
  - Both saturate at 32'hFFFFFFFF and reset to 0 asynchronously.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY = 2: write addr 0x10, byte_en 4'hF, data lanes {0xDE,0xAD,0xBE,0xEF}, then read 0x10 -> mem_ready pulses exactly 2 edges after each acceptance; read returns {0xDE,0xAD,0xBE,0xEF}, mem_error = 0.
- Partial write to addr 0x10, byte_en 4'b0100, lane 2 = 0x55, then read -> {0xDE,0xAD,0x55,0xEF}.
- Read addr 0x13 -> same word as 0x10 (bits [1:0] ignored).
- Read addr 4*DEPTH_WORDS (0x1000 at default) -> mem_ready with mem_error = 1, mem_data_out = 0. Write to the same address -> mem_error = 1 and a later in-range read is unaffected.
- Hold mem_req = 1 continuously -> acceptances every LATENCY+2 cycles; busy high between them; no request accepted during RESP.
- Assert rst_b = 0 during BUSY of a write to 0x20 (old value 0x11223344) -> busy / mem_ready / outputs drop immediately. Post-reset read of 0x20 returns 0x11223344. With DMEM_ACCESS_COUNT_EN: counters = 0 after reset, wr_count unchanged by the aborted write.
